stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller.
// Tracks RUN / PAUSE / ADJ mode, divides the system clock into the 1 Hz run
// tick, the 2 Hz adjust tick and the display blink rate, and issues
// single-cycle increment strobes to the minutes/seconds counter datapath.
// Every output comes straight from a register; inputs only reach outputs
// through the next-state logic.
module stopwatch_ctrl #(
  parameter int DIV_1HZ   = 100000000,
  parameter int DIV_2HZ   = 50000000,
  parameter int DIV_BLINK = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       sec_max,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       paused,
  output logic       adj_blink,
  output logic [1:0] state
);

  localparam int W1 = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
  localparam int W2 = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
  localparam int WB = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;

  localparam logic [W1-1:0] DIV1_LAST  = W1'(DIV_1HZ - 1);
  localparam logic [W2-1:0] DIV2_LAST  = W2'(DIV_2HZ - 1);
  localparam logic [WB-1:0] BLINK_LAST = WB'(DIV_BLINK - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PAUSE = 2'b01,
    ST_ADJ   = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic          pause_flag_reg, pause_flag_next;
  logic [W1-1:0] div1_reg, div1_next;
  logic [W2-1:0] div2_reg, div2_next;
  logic [WB-1:0] blink_cnt_reg, blink_cnt_next;
  logic          sec_inc_reg, sec_inc_next;
  logic          min_inc_reg, min_inc_next;
  logic          adj_blink_reg, adj_blink_next;

  // Ticks are qualified by the mode of the current cycle, so a tick that
  // lands on a mode change is still handled as the mode it occurred in.
  logic tick_run, tick_adj, tick_blink;
  assign tick_run   = (state_reg == ST_RUN) && (div1_reg == DIV1_LAST);
  assign tick_adj   = (state_reg == ST_ADJ) && (div2_reg == DIV2_LAST);
  assign tick_blink = (state_reg == ST_ADJ) && (blink_cnt_reg == BLINK_LAST);

  // Next-state, divider and strobe logic.
  always_comb begin
    pause_flag_next = pause_flag_reg;
    state_next      = ST_RUN;
    div1_next       = div1_reg;
    div2_next       = '0;
    blink_cnt_next  = '0;
    sec_inc_next    = 1'b0;
    min_inc_next    = 1'b0;
    adj_blink_next  = 1'b0;

    // The pause button is ignored while adjusting, so the flag still holds
    // its pre-ADJ value when the switch is released.
    if (pause_pulse && !adj) begin
      pause_flag_next = ~pause_flag_reg;
    end

    if (adj) begin
      state_next = ST_ADJ;
    end else if (pause_flag_next) begin
      state_next = ST_PAUSE;
    end else begin
      state_next = ST_RUN;
    end

    // 1 Hz divider advances only while running and holds otherwise.
    if (state_reg == ST_RUN) begin
      div1_next = tick_run ? '0 : div1_reg + W1'(1);
    end

    // 2 Hz divider restarts from zero every time ADJ is entered.
    if (state_reg == ST_ADJ) begin
      div2_next = tick_adj ? '0 : div2_reg + W2'(1);
    end

    if (tick_run) begin
      sec_inc_next = 1'b1;
      min_inc_next = sec_max;
    end else if (tick_adj) begin
      sec_inc_next = sel;
      min_inc_next = ~sel;
    end

    // Blink starts lit on ADJ entry, then toggles on its own divider.
    if (state_next == ST_ADJ) begin
      if (state_reg != ST_ADJ) begin
        adj_blink_next = 1'b1;
      end else begin
        blink_cnt_next = tick_blink ? '0 : blink_cnt_reg + WB'(1);
        adj_blink_next = tick_blink ? ~adj_blink_reg : adj_blink_reg;
      end
    end
  end

  // State and output registers; reset wins over every input and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      pause_flag_reg <= 1'b0;
      div1_reg       <= '0;
      div2_reg       <= '0;
      blink_cnt_reg  <= '0;
      sec_inc_reg    <= 1'b0;
      min_inc_reg    <= 1'b0;
      adj_blink_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pause_flag_reg <= pause_flag_next;
      div1_reg       <= div1_next;
      div2_reg       <= div2_next;
      blink_cnt_reg  <= blink_cnt_next;
      sec_inc_reg    <= sec_inc_next;
      min_inc_reg    <= min_inc_next;
      adj_blink_reg  <= adj_blink_next;
    end
  end

  assign sec_inc   = sec_inc_reg;
  assign min_inc   = min_inc_reg;
  assign paused    = pause_flag_reg;
  assign adj_blink = adj_blink_reg;
  assign state     = state_reg;

endmodule
